id_ex_ctrl_stage: RTL and testbench
===================================

// Module: id_ex_ctrl_stage
// PURPOSE
//  Issue side of the alu_op/func interface: decodes the ID-stage instruction into main control
//  (alu_op, func, datapath selects) and registers it into the ID/EX pipeline register.
//  Sits between IF/ID and the EX stage; EX alu_control/ALU consume ex_alu_op/ex_func.
//  Also owns load-use hazard detection (bubble insert) and a saturating bubble counter.
// PARAMETERS
//  BUBBLE_CNT_W  8   width of saturating bubble counter
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   synchronous reset, active-low
//  id_valid       in   1   instr holds a real instruction
//  id_instr       in   32  ID-stage instruction
//  stall          in   1   downstream stall: hold whole ID/EX register
//  flush          in   1   branch/exception flush: load bubble into ID/EX
//  hazard_stall   out  1   load-use detected; IF/ID and PC must hold (combinational)
//  illegal        out  1   registered: EX slot came from unknown opcode (1 cycle)
//  ex_valid       out  1   EX slot holds a real instruction
//  ex_alu_op      out  2   00 add(lw/sw/addi), 01 sub(beq), 10 R-type (use func)
//  ex_func        out  6   instr[5:0] (zero for non-R-type)
//  ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  out 1 each
//  ex_rs, ex_rt, ex_rd  out  5   register specifiers
//  ex_imm         out  32  sign-extended instr[15:0]
//  bubble_cnt     out  BUBBLE_CNT_W  bubbles inserted by hazard/flush/illegal, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs/regs 0 (bubble), bubble_cnt 0; overrides everything.
//  Decode (combinational, opcode=instr[31:26]):
//   000000 R:   alu_op 10, reg_dst 1, reg_write 1, func=instr[5:0]
//   100011 lw:  alu_op 00, alu_src 1, mem_read 1, mem_to_reg 1, reg_write 1
//   101011 sw:  alu_op 00, alu_src 1, mem_write 1
//   000100 beq: alu_op 01, branch 1
//   001000 addi: alu_op 00, alu_src 1, reg_write 1
//   other: bubble, illegal=1 next cycle
//  Bubble = ex_valid 0, all controls 0, alu_op 00, func 0; rs/rt/rd/imm 0.
//  Hazard: hazard_stall = id_valid & ex_valid & ex_mem_read & ex_rt!=0 &
//   (ex_rt==instr[25:21] | (ex_rt==instr[20:16] & opcode in {R,sw,beq})).
//  Per-cycle update priority (rst_n=1): flush > stall > hazard > illegal > load.
//   flush: load bubble (even if stall), bubble_cnt+1.  stall: hold all regs, illegal->0.
//   hazard: load bubble, bubble_cnt+1.  illegal opcode & id_valid: bubble, illegal=1, cnt+1.
//   id_valid=0: bubble, no count.  else load decoded fields, latency 1 cycle.
//  hazard_stall may assert during stall; it never alters EX state while stall=1.
//  bubble_cnt saturates at 2^W-1; never wraps.
// STRUCTURE
//  Shared package/header: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI),
//   ALU_OP_ADD/SUB/FUNC encodings (shared with alu_control), ctrl bundle field widths.
//  Sub-module: main_decoder (combinational opcode -> control bundle + illegal).
//  Top: hazard compare, priority mux, ID/EX register, bubble counter.
// TESTING
//  1 Reset: rst_n=0 two cycles mid-stream -> all ex_* 0, bubble_cnt 0.
//  2 Decode: 0x02328020 (add $16,$17,$18) -> ex_alu_op 10, ex_func 100000, reg_dst 1, rd 16;
//    0x8E080004 (lw $8,4($16)) -> alu_op 00, mem_read 1, imm 4; 0x1000FFFF beq -> alu_op 01, imm FFFFFFFF.
//  3 Load-use: lw $8 then add $9,$8,$10 -> hazard_stall 1 one cycle, bubble in EX, add issues next cycle, cnt=1.
//  4 Stall: stall=1 for 3 cycles with new instr -> ex_* unchanged; flush+stall same cycle -> bubble.
//  5 Illegal: opcode 111111 id_valid=1 -> ex_valid 0, illegal pulses 1 cycle, cnt+1.
//  6 Saturation (W=2): 5 flushes -> bubble_cnt stays 3.

Source files
------------

// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared encodings for the ID/EX control stage: opcodes, alu_op encodings
// (shared with the EX-side alu_control), the control bundle carried into EX,
// and the full ID/EX slot payload.
package id_ex_ctrl_stage_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned IMM_W    = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNC = 2'b10;

    // Main control bundle handed to EX
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [FUNC_W-1:0]   func;
        logic                reg_dst;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                reg_write;
        logic                branch;
    } ctrl_t;

    // Complete ID/EX slot; all-zero is a bubble
    typedef struct packed {
        logic               valid;
        ctrl_t              ctrl;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [IMM_W-1:0]   imm;
    } ex_slot_t;

    localparam ctrl_t    CTRL_BUBBLE = '0;
    localparam ex_slot_t SLOT_BUBBLE = '0;

    // Opcodes whose rt field is a source operand (load-use on rt matters)
    function automatic logic reads_rt(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic [IMM_W-1:0] sign_ext16(input logic [15:0] x);
        return {{16{x[15]}}, x};
    endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_main_decoder.sv
// Main decoder: opcode -> control bundle, plus illegal flag for unknown opcodes.
// Ports: opcode/func in (instr[31:26], instr[5:0]); ctrl_c, illegal_c out (combinational).
module id_ex_ctrl_stage_main_decoder
    import id_ex_ctrl_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output ctrl_t      ctrl_c,
    output logic       illegal_c
);

    always_comb begin
        ctrl_c    = CTRL_BUBBLE;
        illegal_c = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_c.alu_op    = ALU_OP_FUNC;
                ctrl_c.func      = func;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl_c.alu_op     = ALU_OP_ADD;
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl_c.alu_op    = ALU_OP_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.alu_op = ALU_OP_SUB;
                ctrl_c.branch = 1'b1;
            end
            OP_ADDI: begin
                ctrl_c.alu_op    = ALU_OP_ADD;
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.reg_write = 1'b1;
            end
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: decodes the ID instruction, detects load-use hazards,
// and registers the control bundle into the ID/EX slot with a saturating
// count of inserted bubbles.
// Ports: clk, rst_n (sync, active-low); id_valid/id_instr from IF/ID;
//   stall/flush from pipeline control; hazard_stall (combinational) to IF/ID+PC;
//   illegal, ex_* slot fields and bubble_cnt registered.
module id_ex_ctrl_stage
    import id_ex_ctrl_stage_pkg::*;
#(
    parameter int unsigned BUBBLE_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [31:0]             id_instr,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    hazard_stall,
    output logic                    illegal,
    output logic                    ex_valid,
    output logic [1:0]              ex_alu_op,
    output logic [5:0]              ex_func,
    output logic                    ex_reg_dst,
    output logic                    ex_alu_src,
    output logic                    ex_mem_read,
    output logic                    ex_mem_write,
    output logic                    ex_mem_to_reg,
    output logic                    ex_reg_write,
    output logic                    ex_branch,
    output logic [4:0]              ex_rs,
    output logic [4:0]              ex_rt,
    output logic [4:0]              ex_rd,
    output logic [31:0]             ex_imm,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    logic [OPCODE_W-1:0] opcode_c;
    logic [REG_W-1:0]    id_rs_c;
    logic [REG_W-1:0]    id_rt_c;
    logic [REG_W-1:0]    id_rd_c;
    ctrl_t               dec_ctrl_c;
    logic                dec_illegal_c;
    logic                unused_shamt_c;

    ex_slot_t                ex_q, ex_d;
    logic                    illegal_q, illegal_d;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic                    cnt_inc_c;

    assign opcode_c       = id_instr[31:26];
    assign id_rs_c        = id_instr[25:21];
    assign id_rt_c        = id_instr[20:16];
    assign id_rd_c        = id_instr[15:11];
    assign unused_shamt_c = ^id_instr[10:6];

    id_ex_ctrl_stage_main_decoder u_main_decoder (
        .opcode    (opcode_c),
        .func      (id_instr[5:0]),
        .ctrl_c    (dec_ctrl_c),
        .illegal_c (dec_illegal_c)
    );

    // Load in EX whose destination (rt) is a source of the ID instruction
    always_comb begin
        hazard_stall = id_valid && ex_q.valid && ex_q.ctrl.mem_read && (ex_q.rt != '0) &&
                       ((ex_q.rt == id_rs_c) ||
                        ((ex_q.rt == id_rt_c) && reads_rt(opcode_c)));
    end

    // Slot update priority: flush > stall > hazard > illegal > load
    always_comb begin
        ex_d      = ex_q;
        illegal_d = 1'b0;
        cnt_inc_c = 1'b0;
        if (flush) begin
            ex_d      = SLOT_BUBBLE;
            cnt_inc_c = 1'b1;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (hazard_stall) begin
            ex_d      = SLOT_BUBBLE;
            cnt_inc_c = 1'b1;
        end else if (id_valid && dec_illegal_c) begin
            ex_d      = SLOT_BUBBLE;
            illegal_d = 1'b1;
            cnt_inc_c = 1'b1;
        end else if (!id_valid) begin
            ex_d = SLOT_BUBBLE;
        end else begin
            ex_d.valid = 1'b1;
            ex_d.ctrl  = dec_ctrl_c;
            ex_d.rs    = id_rs_c;
            ex_d.rt    = id_rt_c;
            ex_d.rd    = id_rd_c;
            ex_d.imm   = sign_ext16(id_instr[15:0]);
        end
    end

    // Saturating bubble counter; holds at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_inc_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + BUBBLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q         <= SLOT_BUBBLE;
            illegal_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            illegal_q    <= illegal_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign illegal       = illegal_q;
    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_func       = ex_q.ctrl.func;
    assign ex_reg_dst    = ex_q.ctrl.reg_dst;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_branch     = ex_q.ctrl.branch;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_imm        = ex_q.imm;
    assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Self-checking bench for id_ex_ctrl_stage: directed scenarios followed by
// random traffic, checked against a cycle-level reference model. A second
// instance with a 2-bit counter exposes saturation quickly.
module tb_id_ex_ctrl_stage;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic [5:0]  func;
        logic [6:0]  ctl;   // reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, stall, flush;
    logic [31:0] id_instr;

    logic        hazard_stall, illegal, ex_valid;
    logic [1:0]  ex_alu_op;
    logic [5:0]  ex_func;
    logic        ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm;
    logic [7:0]  bubble_cnt;

    logic        s_hazard_stall, s_illegal, s_ex_valid;
    logic [1:0]  s_ex_alu_op;
    logic [5:0]  s_ex_func;
    logic        s_reg_dst, s_alu_src, s_mem_read, s_mem_write, s_mem_to_reg, s_reg_write, s_branch;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
    logic [31:0] s_ex_imm;
    logic [1:0]  s_bubble_cnt;

    int n_total = 0;
    int n_bad   = 0;

    exp_t m;
    logic m_ill;
    int   m_cnt, m_cnt2;

    always #5 clk = ~clk;

    id_ex_ctrl_stage #(.BUBBLE_CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .illegal(illegal),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_func(ex_func),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_ctrl_stage #(.BUBBLE_CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .stall(stall), .flush(flush), .hazard_stall(s_hazard_stall), .illegal(s_illegal),
        .ex_valid(s_ex_valid), .ex_alu_op(s_ex_alu_op), .ex_func(s_ex_func),
        .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src), .ex_mem_read(s_mem_read),
        .ex_mem_write(s_mem_write), .ex_mem_to_reg(s_mem_to_reg),
        .ex_reg_write(s_reg_write), .ex_branch(s_branch),
        .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // What an instruction should look like once issued into EX
    function automatic logic is_legal(input logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd8;
    endfunction

    function automatic exp_t issued(input logic [31:0] i);
        exp_t r = '0;
        r.valid = 1'b1;
        r.rs    = i[25:21];
        r.rt    = i[20:16];
        r.rd    = i[15:11];
        r.imm   = {{16{i[15]}}, i[15:0]};
        case (i[31:26])
            6'd0:  begin r.alu_op = 2'd2; r.func = i[5:0]; r.ctl = 7'b1000010; end
            6'd35: begin r.alu_op = 2'd0; r.ctl = 7'b0110110; end
            6'd43: begin r.alu_op = 2'd0; r.ctl = 7'b0101000; end
            6'd4:  begin r.alu_op = 2'd1; r.ctl = 7'b0000001; end
            default: begin r.alu_op = 2'd0; r.ctl = 7'b0100010; end  // addi
        endcase
        return r;
    endfunction

    function automatic logic exp_hazard(input logic v, input logic [31:0] i);
        logic src_rt;
        src_rt = (i[31:26] == 6'd0) || (i[31:26] == 6'd43) || (i[31:26] == 6'd4);
        return v && m.valid && m.ctl[4] && (m.rt != 5'd0) &&
               ((m.rt == i[25:21]) || (src_rt && (m.rt == i[20:16])));
    endfunction

    task automatic check_outputs();
        exp_t s_obs;
        chk("ex_valid", 64'(ex_valid), 64'(m.valid));
        chk("illegal", 64'(illegal), 64'(m_ill));
        chk("ex_alu_op", 64'(ex_alu_op), 64'(m.alu_op));
        chk("ex_func", 64'(ex_func), 64'(m.func));
        chk("ex_ctl", 64'({ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write,
                           ex_mem_to_reg, ex_reg_write, ex_branch}), 64'(m.ctl));
        chk("ex_regs", 64'({ex_rs, ex_rt, ex_rd}), 64'({m.rs, m.rt, m.rd}));
        chk("ex_imm", 64'(ex_imm), 64'(m.imm));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        chk("bubble_cnt_w2", 64'(s_bubble_cnt), 64'(m_cnt2));
        s_obs = {s_ex_valid, s_ex_alu_op, s_ex_func, s_reg_dst, s_alu_src, s_mem_read,
                 s_mem_write, s_mem_to_reg, s_reg_write, s_branch, s_ex_rs, s_ex_rt,
                 s_ex_rd, s_ex_imm};
        chk("w2_slot", 64'(s_obs), 64'(m));
        chk("w2_illegal", 64'(s_illegal), 64'(m_ill));
    endtask

    // One clock: drive, check the hazard output mid-cycle, advance model, check EX
    task automatic step(input logic rn, input logic v, input logic [31:0] ins,
                        input logic st, input logic fl);
        logic haz;
        rst_n = rn; id_valid = v; id_instr = ins; stall = st; flush = fl;
        #4;
        haz = exp_hazard(v, ins);
        chk("hazard_stall", 64'(hazard_stall), 64'(haz));
        chk("hazard_stall_w2", 64'(s_hazard_stall), 64'(haz));
        @(posedge clk);
        if (!rn) begin
            m = '0; m_ill = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_ill = 1'b0;
            if (fl || (!st && (haz || (v && !is_legal(ins[31:26]))))) begin
                m = '0;
                m_ill = !fl && !haz;
                m_cnt  = (m_cnt  < 255) ? m_cnt + 1  : 255;
                m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end else if (!st) begin
                m = v ? issued(ins) : '0;
            end
        end
        #1;
        check_outputs();
    endtask

    localparam logic [31:0] I_ADD  = 32'h02328020;  // add $16,$17,$18
    localparam logic [31:0] I_LW   = 32'h8E080004;  // lw  $8,4($16)
    localparam logic [31:0] I_BEQ  = 32'h1000FFFF;
    localparam logic [31:0] I_USE  = 32'h010A4820;  // add $9,$8,$10
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    initial begin
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] ins;
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43; ops[3] = 6'd4; ops[4] = 6'd8; ops[5] = 6'd0;

        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; stall = 1'b0; flush = 1'b0;
        m = '0; m_ill = 1'b0; m_cnt = 0; m_cnt2 = 0;
        @(posedge clk); @(posedge clk); #1;
        check_outputs();

        // decode examples
        step(1, 1, I_ADD, 0, 0);
        chk("add_alu_op", 64'(ex_alu_op), 64'h2);
        chk("add_func", 64'(ex_func), 64'h20);
        chk("add_rd", 64'({ex_reg_dst, ex_rd}), 64'({1'b1, 5'd16}));
        step(1, 1, I_LW, 0, 0);
        chk("lw_ctl", 64'({ex_alu_op, ex_mem_read, ex_imm}), 64'({2'b00, 1'b1, 32'd4}));
        step(1, 1, I_BEQ, 0, 0);
        chk("beq_ctl", 64'({ex_alu_op, ex_imm}), 64'({2'b01, 32'hFFFFFFFF}));

        // load-use: one bubble, then the consumer issues
        step(1, 1, I_LW, 0, 0);
        step(1, 1, I_USE, 0, 0);
        chk("lu_bubble", 64'({ex_valid, bubble_cnt}), 64'({1'b0, 8'd1}));
        step(1, 1, I_USE, 0, 0);
        chk("lu_issue", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd9}));

        // stall holds EX, flush beats stall
        step(1, 1, I_ADD, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 1, I_LW, 1, 0);
        chk("stall_hold", 64'({ex_valid, ex_rd, ex_mem_read}), 64'({1'b1, 5'd16, 1'b0}));
        step(1, 1, I_LW, 1, 1);
        chk("flush_stall", 64'(ex_valid), 64'h0);

        // illegal pulses for one cycle
        step(1, 1, I_ILL, 0, 0);
        chk("ill_pulse", 64'({illegal, ex_valid}), 64'({1'b1, 1'b0}));
        step(1, 1, I_ADD, 0, 0);
        chk("ill_clear", 64'(illegal), 64'h0);

        // 2-bit counter saturation
        for (int k = 0; k < 5; k++) step(1, 1, I_ADD, 0, 1);
        chk("sat_w2", 64'(s_bubble_cnt), 64'h3);

        // mid-stream reset
        step(0, 1, I_LW, 0, 0);
        step(0, 1, I_ADD, 0, 1);
        chk("rst_state", 64'({ex_valid, illegal, bubble_cnt, s_bubble_cnt}), 64'h0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            op  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0), ins,
                 ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
